// File: rtl/adc_pkg.sv
// Shared types and defaults for the dual-channel ADC SPI capture front end.
// Holds the FSM state encoding, frame length and counter-sizing helpers.
package adc_pkg;

  localparam int unsigned FRAME_BITS        = 16;
  localparam int unsigned CLK_DIV_DEF       = 4;
  localparam int unsigned SAMPLE_PERIOD_DEF = 250;
  localparam int unsigned QUIET_CYC_DEF     = 8;

  typedef enum logic [1:0] {
    StIdle,
    StLead,
    StShift,
    StQuiet
  } adc_state_e;

  // Width of a counter running 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Frame bits above the sample field; any 1 there marks a bad frame.
  function automatic logic [FRAME_BITS-1:0] lead_mask(input int unsigned data_w);
    logic [FRAME_BITS-1:0] m;
    m = '0;
    for (int i = 0; i < FRAME_BITS; i++) begin
      if (i >= data_w) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: half-period counter plus toggle, idling high.
// rise/fall flag the cycle in which sclk is driven low->high / high->low.
module spi_sclk_gen
  import adc_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = cnt_w(CLK_DIV);
  localparam logic [CW-1:0] CntMax = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          wrap;

  assign wrap = run && (cnt_q == CntMax);
  assign rise = wrap && !sclk_q;
  assign fall = wrap && sclk_q;
  assign sclk = sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    // clr lets the owner park sclk high on the cycle a frame ends
    if (!run || clr) begin
      cnt_d  = '0;
      sclk_d = 1'b1;
    end else if (wrap) begin
      cnt_d  = '0;
      sclk_d = !sclk_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/adc_spi_reader.sv
// Dual-channel SPI capture for a pair of 12-bit serial ADCs with shared CS/SCLK.
// Periodically runs a 16-bit frame and presents both samples with a valid strobe.
module adc_spi_reader
  import adc_pkg::*;
#(
  parameter int unsigned CLK_DIV       = CLK_DIV_DEF,
  parameter int unsigned SAMPLE_PERIOD = SAMPLE_PERIOD_DEF,
  parameter int unsigned QUIET_CYC     = QUIET_CYC_DEF,
  parameter int unsigned DATA_W        = 12
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              En,
  input  logic              Sdata0,
  input  logic              Sdata1,
  output logic              Cs_n,
  output logic              Sclk,
  output logic [DATA_W-1:0] data0,
  output logic [DATA_W-1:0] data1,
  output logic              valid,
  output logic              frame_err,
  output logic              overrun
);

  localparam int unsigned PW = cnt_w(SAMPLE_PERIOD);
  localparam int unsigned QW = cnt_w(QUIET_CYC);
  localparam int unsigned BW = cnt_w(FRAME_BITS);
  localparam logic [PW-1:0] PerMax   = PW'(SAMPLE_PERIOD - 1);
  localparam logic [QW-1:0] QuietMax = QW'(QUIET_CYC - 1);
  localparam logic [BW-1:0] BitMax   = BW'(FRAME_BITS - 1);
  localparam logic [FRAME_BITS-1:0] LeadMask = lead_mask(DATA_W);

  adc_state_e state_q, state_d;

  logic [PW-1:0]         per_q, per_d;
  logic [QW-1:0]         quiet_q, quiet_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [FRAME_BITS-1:0] sh0_q, sh0_d, sh1_q, sh1_d;
  logic [DATA_W-1:0]     data0_q, data0_d, data1_q, data1_d;
  logic                  cs_n_q, cs_n_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  ovr_q, ovr_d;

  logic tick;
  logic sclk_run, sclk_clr, sclk_rise, sclk_fall;

  assign tick     = (per_q == PerMax);
  assign per_d    = tick ? '0 : per_q + 1'b1;
  assign sclk_run = (state_q == StLead) || (state_q == StShift);

  // LEAD is simply the first high half-period; its falling edge starts SHIFT.
  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk  (Clk),
    .rst  (Rst),
    .run  (sclk_run),
    .clr  (sclk_clr),
    .sclk (Sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  always_comb begin
    state_d  = state_q;
    quiet_d  = quiet_q;
    bit_d    = bit_q;
    sh0_d    = sh0_q;
    sh1_d    = sh1_q;
    data0_d  = data0_q;
    data1_d  = data1_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    sclk_clr = 1'b0;
    ovr_d    = tick && (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (tick && En) state_d = StLead;
      end
      StLead: begin
        if (sclk_fall) state_d = StShift;
      end
      StShift: begin
        if (sclk_rise) begin
          sh0_d = {sh0_q[FRAME_BITS-2:0], Sdata0};
          sh1_d = {sh1_q[FRAME_BITS-2:0], Sdata1};
        end
        // bit_q advances at the end of each high phase; the 16th ends the frame
        if (sclk_fall) begin
          if (bit_q == BitMax) begin
            state_d  = StQuiet;
            bit_d    = '0;
            sclk_clr = 1'b1;
            valid_d  = 1'b1;
            data0_d  = sh0_q[DATA_W-1:0];
            data1_d  = sh1_q[DATA_W-1:0];
            err_d    = |((sh0_q | sh1_q) & LeadMask);
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      StQuiet: begin
        if (quiet_q == QuietMax) begin
          state_d = StIdle;
          quiet_d = '0;
        end else begin
          quiet_d = quiet_q + 1'b1;
        end
      end
    endcase

    cs_n_d = !((state_d == StLead) || (state_d == StShift));
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= StIdle;
      per_q   <= '0;
      quiet_q <= '0;
      bit_q   <= '0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      data0_q <= '0;
      data1_q <= '0;
      cs_n_q  <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      quiet_q <= quiet_d;
      bit_q   <= bit_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      cs_n_q  <= cs_n_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  assign Cs_n      = cs_n_q;
  assign data0     = data0_q;
  assign data1     = data1_q;
  assign valid     = valid_q;
  assign frame_err = err_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Scoreboard bench for adc_spi_reader: default-period instance plus a short-period
// instance that exercises overrun.
`timescale 1ns/1ps
module tb_adc_spi_reader;

  typedef struct {
    logic [15:0] w0;
    logic [15:0] w1;
    logic [11:0] d0;
    logic [11:0] d1;
    logic        err;
    int          cyc;
    bit          chk;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [11:0] d0;
    logic [11:0] d1;
    logic        err;
  } exp_t;

  localparam logic [15:0] W0_B = 16'h0A5C;
  localparam logic [15:0] W1_B = 16'h03C1;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic en_a = 1'b0;
  logic en_b = 1'b0;

  logic        sd0_a, sd1_a, cs_n_a, sclk_a, valid_a, err_a, ovr_a;
  logic [11:0] data0_a, data1_a;
  logic        sd0_b, sd1_b, cs_n_b, sclk_b, valid_b, err_b, ovr_b;
  logic [11:0] data0_b, data1_b;

  int n_pass = 0;
  int n_total = 0;
  int cyc_a, cyc_b;
  bit b_active = 1'b1;

  vec_t        vecs [8];
  exp_t        exp_q[$];
  exp_t        e;
  logic [15:0] adc0_q[$];
  logic [15:0] adc1_q[$];
  int          qv_b[$];
  int          qo_b[$];
  int          vb, ob;

  logic [15:0] w0_a = '0, w1_a = '0;
  logic [3:0]  idx_a = 4'd15, idx_b = 4'd15;
  int          rises_a = 0;

  always #4 clk = ~clk;

  adc_spi_reader u_dut_a (
    .Clk       (clk),
    .Rst       (rst_a),
    .En        (en_a),
    .Sdata0    (sd0_a),
    .Sdata1    (sd1_a),
    .Cs_n      (cs_n_a),
    .Sclk      (sclk_a),
    .data0     (data0_a),
    .data1     (data1_a),
    .valid     (valid_a),
    .frame_err (err_a),
    .overrun   (ovr_a)
  );

  adc_spi_reader #(
    .SAMPLE_PERIOD (100)
  ) u_dut_b (
    .Clk       (clk),
    .Rst       (rst_b),
    .En        (en_b),
    .Sdata0    (sd0_b),
    .Sdata1    (sd1_b),
    .Cs_n      (cs_n_b),
    .Sclk      (sclk_b),
    .data0     (data0_b),
    .data1     (data1_b),
    .valid     (valid_b),
    .frame_err (err_b),
    .overrun   (ovr_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc_a < n) @(negedge clk);
  endtask

  always @(posedge clk or posedge rst_a)
    if (rst_a) cyc_a <= 0;
    else cyc_a <= cyc_a + 1;

  always @(posedge clk or posedge rst_b)
    if (rst_b) cyc_b <= 0;
    else cyc_b <= cyc_b + 1;

  // ADC model A: MSB out on CS fall, next bit after each SCLK rise.
  always @(negedge cs_n_a) begin
    if (!rst_a) begin
      if (adc0_q.size() > 0) begin
        w0_a = adc0_q.pop_front();
        w1_a = adc1_q.pop_front();
      end else begin
        w0_a = '0;
        w1_a = '0;
      end
      idx_a   = 4'd15;
      rises_a = 0;
    end
  end

  always @(posedge sclk_a) begin
    if (!cs_n_a) begin
      rises_a++;
      if (idx_a != 0) idx_a = idx_a - 1'b1;
    end
  end

  assign sd0_a = w0_a[idx_a];
  assign sd1_a = w1_a[idx_a];

  always @(posedge cs_n_a) begin
    if (!rst_a) check("sclk_rises_per_frame", rises_a, 16);
  end

  // ADC model B: fixed words every frame.
  always @(negedge cs_n_b) if (!rst_b) idx_b = 4'd15;
  always @(posedge sclk_b) if (!cs_n_b && idx_b != 0) idx_b = idx_b - 1'b1;
  assign sd0_b = W0_B[idx_b];
  assign sd1_b = W1_B[idx_b];

  // Monitor A
  always @(negedge clk) begin
    if (!rst_a) begin
      if (valid_a) begin
        if (exp_q.size() == 0) begin
          check("a_valid_unexpected", valid_a, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("a_valid_cycle", cyc_a, e.cyc);
          check("a_data0", data0_a, e.d0);
          check("a_data1", data1_a, e.d1);
          check("a_frame_err", err_a, e.err);
        end
      end else if (err_a) begin
        check("a_frame_err_without_valid", err_a, 1'b0);
      end
      if (ovr_a) check("a_overrun_unexpected", ovr_a, 1'b0);
    end
  end

  // Monitor B
  always @(negedge clk) begin
    if (!rst_b && b_active) begin
      if (valid_b) begin
        if (qv_b.size() == 0) begin
          check("b_valid_unexpected", valid_b, 1'b0);
        end else begin
          vb = qv_b.pop_front();
          check("b_valid_cycle", cyc_b, vb);
          check("b_data0", data0_b, 12'hA5C);
          check("b_data1", data1_b, 12'h3C1);
          check("b_frame_err", err_b, 1'b0);
        end
      end
      if (ovr_b) begin
        if (qo_b.size() == 0) begin
          check("b_overrun_unexpected", ovr_b, 1'b0);
        end else begin
          ob = qo_b.pop_front();
          check("b_overrun_cycle", cyc_b, ob);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    vecs[0] = '{16'h0ABC, 16'h0123, 12'hABC, 12'h123, 1'b0, 382, 1'b1};
    vecs[1] = '{16'h0FFF, 16'h0456, 12'hFFF, 12'h456, 1'b0, 632, 1'b1};
    vecs[2] = '{16'h0000, 16'h0789, 12'h000, 12'h789, 1'b0, 882, 1'b1};
    vecs[3] = '{16'h0800, 16'h8001, 12'h800, 12'h001, 1'b1, 1132, 1'b1};
    vecs[4] = '{16'h1234, 16'h0FED, 12'h234, 12'hFED, 1'b1, 1382, 1'b1};
    vecs[5] = '{16'h0F0F, 16'h0CAF, 12'hF0F, 12'hCAF, 1'b0, 1632, 1'b1};
    vecs[6] = '{16'h0555, 16'h0AAA, 12'h000, 12'h000, 1'b0, 0, 1'b0};
    vecs[7] = '{16'h0DEF, 16'h0321, 12'hDEF, 12'h321, 1'b0, 382, 1'b1};

    repeat (3) @(negedge clk);
    #1;
    check("reset_cs_n", cs_n_a, 1'b1);
    check("reset_sclk", sclk_a, 1'b1);
    check("reset_data0", data0_a, 12'h000);
    check("reset_data1", data1_a, 12'h000);
    check("reset_valid", valid_a, 1'b0);
    check("reset_frame_err", err_a, 1'b0);
    check("reset_overrun", ovr_a, 1'b0);

    for (int i = 0; i < 8; i++) begin
      adc0_q.push_back(vecs[i].w0);
      adc1_q.push_back(vecs[i].w1);
      if (vecs[i].chk) exp_q.push_back('{vecs[i].cyc, vecs[i].d0, vecs[i].d1, vecs[i].err});
    end
    qv_b = '{232, 432, 632, 832};
    qo_b = '{200, 400, 600, 800};

    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    en_a  = 1'b1;
    en_b  = 1'b1;

    wait_cyc(950);
    b_active = 1'b0;
    check("b_valid_queue_drained", qv_b.size(), 0);
    check("b_overrun_queue_drained", qo_b.size(), 0);

    // Drop En mid-SHIFT of the frame started at cycle 1499.
    wait_cyc(1550);
    check("cs_low_before_en_drop", cs_n_a, 1'b0);
    en_a = 1'b0;
    wait_cyc(1632);
    bad = 0;
    while (cyc_a < 2382) begin
      @(negedge clk);
      if (cs_n_a !== 1'b1 || sclk_a !== 1'b1) bad++;
    end
    check("idle_three_periods_after_en_drop", bad, 0);

    wait_cyc(2400);
    en_a = 1'b1;
    wait_cyc(2560);
    check("cs_low_before_reset", cs_n_a, 1'b0);
    rst_a = 1'b1;
    #1;
    check("midframe_reset_cs_n", cs_n_a, 1'b1);
    check("midframe_reset_sclk", sclk_a, 1'b1);
    check("midframe_reset_data0", data0_a, 12'h000);
    check("midframe_reset_valid", valid_a, 1'b0);
    repeat (2) @(negedge clk);
    rst_a = 1'b0;

    wait_cyc(390);
    check("a_expect_queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/adc_spi_reader.md
Name: adc_spi_reader

Overview:
Dual-channel SPI capture front end for the board's 12-bit serial ADC pair (AD7476-style, shared CS/SCLK, one data line per channel). It is the receive-side counterpart of the sine sample source: it periodically starts a conversion, shifts in 16-bit frames and presents 12-bit samples with a one-cycle valid strobe. Results feed the loopback checker and the DAC path.

Parameters:
CLK_DIV, 4, Clk cycles per SCLK half-period (SCLK = Clk/(2*CLK_DIV)); legal range 2 or more
SAMPLE_PERIOD, 250, Clk cycles between conversion starts; must be at least CLK_DIV*33+QUIET_CYC+2
QUIET_CYC, 8, Clk cycles CS held high after a frame before the next start can be accepted
DATA_W, 12, sample width; frame length fixed at 16 bits, so DATA_W is at most 16

Ports:
Clk  in  1  system clock (125 MHz)
Rst  in  1  asynchronous, active-high reset
En  in  1  conversion enable; sampled at each period tick
Sdata0  in  1  ADC channel 0 serial data
Sdata1  in  1  ADC channel 1 serial data
Cs_n  out  1  ADC chip select, active low
Sclk  out  1  ADC serial clock, idles high
data0  out  DATA_W  latest channel 0 sample
data1  out  DATA_W  latest channel 1 sample
valid  out  1  one-cycle pulse when data0 and data1 update together
frame_err  out  1  one-cycle pulse with valid if any leading bit (frame bits 15..DATA_W) is 1 on either channel
overrun  out  1  one-cycle pulse when a period tick occurs while a frame is in progress

Behaviour:
- Reset (asynchronous, immediate): Cs_n=1, Sclk=1, data0=data1=0, valid=frame_err=overrun=0, FSM goes to IDLE, all counters 0.
- Period counter: free-running from 0 to SAMPLE_PERIOD-1 and wraps. A tick is generated when the count equals SAMPLE_PERIOD-1. It is independent of En.
- FSM states: IDLE, LEAD, SHIFT, QUIET. All outputs are registered.
- IDLE: Cs_n=1, Sclk=1. On a tick with En=1, go to LEAD; Cs_n falls on the next cycle. On a tick with En=0, stay in IDLE.
- LEAD: Cs_n=0, Sclk=1 for CLK_DIV cycles (setup time), then go to SHIFT.
- SHIFT: 16 bits, MSB first. For each bit, Sclk is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - Sdata0 and Sdata1 are sampled into two 16-bit shift registers on the Clk cycle in which Sclk is driven low to high.
  - After the 16th high phase, go to QUIET.
- QUIET: entry cycle asserts Cs_n=1 and Sclk=1.
  - On the same cycle: valid=1, data0/data1 = shift register bits [DATA_W-1:0], and frame_err is computed from bits [15:DATA_W] of both channels.
  - Hold QUIET for QUIET_CYC cycles, then go to IDLE.
- Frame timing with defaults: 1 cycle to CS fall, plus 4 LEAD cycles, plus 128 SHIFT cycles. valid fires 133 Clk cycles after the tick cycle.
- overrun: a tick arriving in LEAD, SHIFT or QUIET pulses overrun for one cycle. The tick is otherwise dropped and the frame in progress is unaffected.
- En deasserted mid-frame: the current frame completes and produces valid; no new frame starts.
- data0/data1 hold their value between valid pulses.
- Sdata is sampled directly, with no synchronizer (source-synchronous with Sclk). Input timing is covered by constraints.
- Counters use $clog2 widths of their respective maxima. Bit counter range is 0..15; the half-period counter range is 0..CLK_DIV-1.

Decomposition:
- Shared package adc_pkg: FSM state enum (IDLE, LEAD, SHIFT, QUIET), the FRAME_BITS=16 constant, and the default values of CLK_DIV, SAMPLE_PERIOD and QUIET_CYC.
- One natural sub-module: spi_sclk_gen. It is the half-period counter plus Sclk toggle and emits rise/fall strobes; the FSM consumes these strobes.
- The two channel shift registers stay inline.

Test Plan:
- Reset then En=1; the ADC model returns 16'h0ABC on ch0 and 16'h0123 on ch1. Expect valid at 133 cycles after the tick, with data0=12'hABC, data1=12'h123 and frame_err=0.
- Consecutive frames: ch0 returns 0FFF, then 0000, then 0800. Expect valid pulses exactly 250 cycles apart, with data0 equal to FFF, then 000, then 800. Check exactly 16 Sclk rising edges per Cs_n low window.
- Leading-bit error: ch1 returns 16'h8001. Expect data1=12'h001 and frame_err=1 in the same cycle as valid.
- Deassert En during SHIFT. Expect the current frame to complete with valid=1; Cs_n then stays 1 and Sclk stays 1 for the next 3 periods.
- Use SAMPLE_PERIOD=100 (less than the frame length). Expect an overrun pulse on a tick during a frame and no corruption of data0.
- Assert Rst mid-SHIFT. Expect Cs_n=1, Sclk=1 and data0=0 in the same timestep with no valid. After release, the first frame is normal.
